// File: rtl/time_core_alarm.sv
// -----------------------------------------------------------------------------
// time_core_alarm
//
// Timekeeping core for the DE2 digital clock. A prescaler derives a sub-second
// tick from CLOCK_50 and drives a BCD cascade (sub-second, second, minute,
// hour). A debounced pushbutton edits one field at a time while in adjust mode.
// A daily alarm with an acknowledge/timeout state machine rings when the time
// reaches the programmed hour:minute.
//
// Parameters
//   CLK_HZ      input clock frequency, integer multiple of TICK_HZ
//   TICK_HZ     sub-second ticks per second (1, 10 or 100)
//   DB_CYCLES   cycles the synchronised button must be stable to be accepted
//   ALARM_SECS  seconds the alarm rings without acknowledge
//
// Ports
//   CLOCK_50      in   system clock
//   clr           in   asynchronous active-low reset
//   add           in   raw pushbutton, active-low, asynchronous
//   adjust        in   1 = edit mode (timekeeping halted), 0 = run
//   select[2:0]   in   field to edit: 0 sec, 1 min, 2 hour, 3 alarm min,
//                      4 alarm hour, 5..7 ignored
//   alarm_en      in   alarm arm level
//   alarm_ack     in   acknowledge level
//   subsec[7:0]   out  BCD sub-second 00..TICK_HZ-1
//   second[6:0]   out  BCD 00..59
//   minute[6:0]   out  BCD 00..59
//   hour[5:0]     out  BCD 00..23
//   alarm_min     out  BCD alarm minute
//   alarm_hour    out  BCD alarm hour
//   alarm_active  out  alarm ringing
//   sec_pulse     out  one-cycle pulse on every run-mode second increment
// -----------------------------------------------------------------------------
module time_core_alarm #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int TICK_HZ    = 100,
    parameter int DB_CYCLES  = 1_000_000,
    parameter int ALARM_SECS = 60
) (
    input  logic       CLOCK_50,
    input  logic       clr,
    input  logic       add,
    input  logic       adjust,
    input  logic [2:0] select,
    input  logic       alarm_en,
    input  logic       alarm_ack,
    output logic [7:0] subsec,
    output logic [6:0] second,
    output logic [6:0] minute,
    output logic [5:0] hour,
    output logic [6:0] alarm_min,
    output logic [5:0] alarm_hour,
    output logic       alarm_active,
    output logic       sec_pulse
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int ASW = (ALARM_SECS > 1) ? $clog2(ALARM_SECS) : 1;

    // Terminal sub-second value expressed in BCD (99, 09 or 00).
    localparam logic [7:0] SUBSEC_MAX = 8'((((TICK_HZ - 1) / 10) * 16) + ((TICK_HZ - 1) % 10));

    typedef enum logic {
        ALM_IDLE,
        ALM_RINGING
    } alm_state_t;

    // BCD increment of a two-digit value, wrapping to 00 after max_v.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
        logic [7:0] r;
        if (v == max_v) begin
            r = 8'h00;
        end else if (v[3:0] == 4'h9) begin
            r = {v[7:4] + 4'h1, 4'h0};
        end else begin
            r = {v[7:4], v[3:0] + 4'h1};
        end
        return r;
    endfunction

    // ---------------------------------------------------------------- state
    logic [PW-1:0]  presc_q, presc_d;
    logic [7:0]     subsec_q, subsec_d;
    logic [6:0]     second_q, second_d;
    logic [6:0]     minute_q, minute_d;
    logic [5:0]     hour_q, hour_d;
    logic [6:0]     alarm_min_q, alarm_min_d;
    logic [5:0]     alarm_hour_q, alarm_hour_d;
    logic           sec_pulse_q, sec_pulse_d;

    logic [1:0]     sync_q, sync_d;
    logic           db_level_q, db_level_d;
    logic [DBW-1:0] db_cnt_q, db_cnt_d;
    logic           press_q, press_d;

    alm_state_t     state_q, state_d;
    logic [ASW-1:0] alarm_cnt_q, alarm_cnt_d;
    logic           alarm_active_q, alarm_active_d;

    logic           tick;
    logic           alarm_match;

    // --------------------------------------------------- button debouncer
    always_comb begin
        sync_d     = {sync_q[0], add};
        db_level_d = db_level_q;
        db_cnt_d   = db_cnt_q;
        press_d    = 1'b0;
        if (sync_q[1] == db_level_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DBW'(DB_CYCLES - 1)) begin
            // DB_CYCLES consecutive samples differed from the accepted level.
            db_level_d = sync_q[1];
            db_cnt_d   = '0;
            press_d    = ~sync_q[1];
        end else begin
            db_cnt_d = db_cnt_q + DBW'(1);
        end
    end

    // --------------------------------------------- prescaler and cascade
    always_comb begin
        presc_d      = presc_q;
        subsec_d     = subsec_q;
        second_d     = second_q;
        minute_d     = minute_q;
        hour_d       = hour_q;
        alarm_min_d  = alarm_min_q;
        alarm_hour_d = alarm_hour_q;
        sec_pulse_d  = 1'b0;
        tick         = 1'b0;

        if (adjust) begin
            presc_d = '0;
        end else if (presc_q == PW'(DIV - 1)) begin
            presc_d = '0;
            tick    = 1'b1;
        end else begin
            presc_d = presc_q + PW'(1);
        end

        if (tick) begin
            subsec_d = bcd_inc(subsec_q, SUBSEC_MAX);
            // With TICK_HZ=1 SUBSEC_MAX is 00, so every tick carries.
            if (subsec_q == SUBSEC_MAX) begin
                sec_pulse_d = 1'b1;
                second_d    = 7'(bcd_inc({1'b0, second_q}, 8'h59));
                if (second_q == 7'h59) begin
                    minute_d = 7'(bcd_inc({1'b0, minute_q}, 8'h59));
                    if (minute_q == 7'h59) begin
                        hour_d = 6'(bcd_inc({2'b00, hour_q}, 8'h23));
                    end
                end
            end
        end

        // Edits never carry into neighbouring fields; tick is idle in adjust.
        if (press_q && adjust) begin
            case (select)
                3'd0: begin
                    second_d = 7'(bcd_inc({1'b0, second_q}, 8'h59));
                    subsec_d = 8'h00;
                    presc_d  = '0;
                end
                3'd1: minute_d     = 7'(bcd_inc({1'b0, minute_q}, 8'h59));
                3'd2: hour_d       = 6'(bcd_inc({2'b00, hour_q}, 8'h23));
                3'd3: alarm_min_d  = 7'(bcd_inc({1'b0, alarm_min_q}, 8'h59));
                3'd4: alarm_hour_d = 6'(bcd_inc({2'b00, alarm_hour_q}, 8'h23));
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------ alarm FSM
    // The match is evaluated on the registered fields in the cycle sec_pulse
    // is high, i.e. right after the tick that wrapped second to 00. That
    // entry pulse is consumed as the trigger, so the timeout counts only the
    // following ALARM_SECS second pulses.
    always_comb begin
        state_d     = state_q;
        alarm_cnt_d = alarm_cnt_q;
        alarm_match = sec_pulse_q && (second_q == 7'h00) &&
                      (minute_q == alarm_min_q) && (hour_q == alarm_hour_q);
        case (state_q)
            ALM_IDLE: begin
                if (alarm_match && alarm_en && !adjust) begin
                    state_d     = ALM_RINGING;
                    alarm_cnt_d = '0;
                end
            end
            ALM_RINGING: begin
                if (alarm_ack || !alarm_en || adjust) begin
                    state_d = ALM_IDLE;
                end else if (sec_pulse_q) begin
                    if (alarm_cnt_q == ASW'(ALARM_SECS - 1)) begin
                        state_d = ALM_IDLE;
                    end else begin
                        alarm_cnt_d = alarm_cnt_q + ASW'(1);
                    end
                end
            end
            default: state_d = ALM_IDLE;
        endcase
        alarm_active_d = (state_d == ALM_RINGING);
    end

    // ------------------------------------------------------- registers
    always_ff @(posedge CLOCK_50 or negedge clr) begin
        if (!clr) begin
            presc_q        <= '0;
            subsec_q       <= 8'h00;
            second_q       <= 7'h00;
            minute_q       <= 7'h00;
            hour_q         <= 6'h00;
            alarm_min_q    <= 7'h00;
            alarm_hour_q   <= 6'h07;
            sec_pulse_q    <= 1'b0;
            sync_q         <= 2'b11;
            db_level_q     <= 1'b1;
            db_cnt_q       <= '0;
            press_q        <= 1'b0;
            state_q        <= ALM_IDLE;
            alarm_cnt_q    <= '0;
            alarm_active_q <= 1'b0;
        end else begin
            presc_q        <= presc_d;
            subsec_q       <= subsec_d;
            second_q       <= second_d;
            minute_q       <= minute_d;
            hour_q         <= hour_d;
            alarm_min_q    <= alarm_min_d;
            alarm_hour_q   <= alarm_hour_d;
            sec_pulse_q    <= sec_pulse_d;
            sync_q         <= sync_d;
            db_level_q     <= db_level_d;
            db_cnt_q       <= db_cnt_d;
            press_q        <= press_d;
            state_q        <= state_d;
            alarm_cnt_q    <= alarm_cnt_d;
            alarm_active_q <= alarm_active_d;
        end
    end

    assign subsec       = subsec_q;
    assign second       = second_q;
    assign minute       = minute_q;
    assign hour         = hour_q;
    assign alarm_min    = alarm_min_q;
    assign alarm_hour   = alarm_hour_q;
    assign alarm_active = alarm_active_q;
    assign sec_pulse    = sec_pulse_q;

endmodule

// File: tb/tb_time_core_alarm.sv
// -----------------------------------------------------------------------------
// tb_time_core_alarm
//
// Directed bench for time_core_alarm with CLK_HZ=1000, TICK_HZ=10,
// DB_CYCLES=4, ALARM_SECS=3 (100 cycles per tick, 1000 cycles per second).
// Expected values are hand-computed BCD constants.
// -----------------------------------------------------------------------------
module tb_time_core_alarm;

    logic       clk = 1'b0;
    logic       clr;
    logic       add;
    logic       adjust;
    logic [2:0] select;
    logic       alarm_en;
    logic       alarm_ack;
    logic [7:0] subsec;
    logic [6:0] second;
    logic [6:0] minute;
    logic [5:0] hour;
    logic [6:0] alarm_min;
    logic [5:0] alarm_hour;
    logic       alarm_active;
    logic       sec_pulse;

    int n_vec = 0;
    int n_err = 0;

    time_core_alarm #(
        .CLK_HZ    (1000),
        .TICK_HZ   (10),
        .DB_CYCLES (4),
        .ALARM_SECS(3)
    ) dut (
        .CLOCK_50    (clk),
        .clr         (clr),
        .add         (add),
        .adjust      (adjust),
        .select      (select),
        .alarm_en    (alarm_en),
        .alarm_ack   (alarm_ack),
        .subsec      (subsec),
        .second      (second),
        .minute      (minute),
        .hour        (hour),
        .alarm_min   (alarm_min),
        .alarm_hour  (alarm_hour),
        .alarm_active(alarm_active),
        .sec_pulse   (sec_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("vec %0d %s: observed %0h expected %0h", n_vec, tag, obs, exp);
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Clean presses: 10 cycles low, 10 cycles released.
    task automatic press(input int n);
        for (int i = 0; i < n; i++) begin
            add = 1'b0;
            step(10);
            add = 1'b1;
            step(10);
        end
    endtask

    task automatic edit(input logic [2:0] sel, input int n);
        select = sel;
        press(n);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clr       = 1'b0;
        add       = 1'b1;
        adjust    = 1'b0;
        select    = 3'd0;
        alarm_en  = 1'b0;
        alarm_ack = 1'b0;
        step(3);

        // Reset state
        check("rst_subsec", subsec, 8'h00);
        check("rst_second", second, 7'h00);
        check("rst_minute", minute, 7'h00);
        check("rst_hour", hour, 6'h00);
        check("rst_alarm_min", alarm_min, 7'h00);
        check("rst_alarm_hour", alarm_hour, 6'h07);
        check("rst_alarm_active", alarm_active, 1'b0);
        check("rst_sec_pulse", sec_pulse, 1'b0);
        clr = 1'b1;

        // Set 12:34:56 through the button, then run to .7
        adjust = 1'b1;
        edit(3'd2, 12);
        edit(3'd1, 34);
        edit(3'd0, 56);
        check("set_hour", hour, 6'h12);
        check("set_minute", minute, 7'h34);
        check("set_second", second, 7'h56);
        adjust = 1'b0;
        step(700);
        check("run_subsec7", subsec, 8'h07);
        check("run_second56", second, 7'h56);

        // Asynchronous reset mid-count
        step(50);
        #3;
        clr = 1'b0;
        #1;
        check("async_subsec", subsec, 8'h00);
        check("async_second", second, 7'h00);
        check("async_minute", minute, 7'h00);
        check("async_hour", hour, 6'h00);
        check("async_alarm_hour", alarm_hour, 6'h07);
        check("async_alarm_min", alarm_min, 7'h00);
        check("async_alarm_active", alarm_active, 1'b0);
        step(2);
        clr = 1'b1;
        step(99);
        check("first_tick_pre", subsec, 8'h00);
        step(1);
        check("first_tick", subsec, 8'h01);

        // Rollover from 23:59:59.9
        adjust = 1'b1;
        edit(3'd2, 23);
        edit(3'd1, 59);
        edit(3'd0, 59);
        check("pre_roll_hour", hour, 6'h23);
        check("pre_roll_minute", minute, 7'h59);
        check("pre_roll_second", second, 7'h59);
        check("sec_edit_clears_subsec", subsec, 8'h00);
        adjust = 1'b0;
        step(900);
        check("roll_subsec9", subsec, 8'h09);
        step(99);
        check("roll_pre_second", second, 7'h59);
        check("roll_pre_pulse", sec_pulse, 1'b0);
        step(1);
        check("roll_subsec", subsec, 8'h00);
        check("roll_second", second, 7'h00);
        check("roll_minute", minute, 7'h00);
        check("roll_hour", hour, 6'h00);
        check("roll_pulse", sec_pulse, 1'b1);
        step(1);
        check("roll_pulse_once", sec_pulse, 1'b0);

        // Adjust: hour wraps 23 -> 00 with no carry
        adjust = 1'b1;
        edit(3'd2, 23);
        check("adj_hour23", hour, 6'h23);
        press(1);
        check("adj_hour_wrap", hour, 6'h00);
        check("adj_minute_kept", minute, 7'h00);

        // 3-cycle glitch must be rejected
        add = 1'b0;
        step(3);
        add = 1'b1;
        step(10);
        check("glitch_hour", hour, 6'h00);

        // select 6 is ignored
        edit(3'd6, 1);
        check("sel6_hour", hour, 6'h00);
        check("sel6_second", second, 7'h00);
        check("sel6_alarm_hour", alarm_hour, 6'h07);
        check("sel6_alarm_min", alarm_min, 7'h00);

        // Frozen in adjust
        step(500);
        check("freeze_subsec", subsec, 8'h00);
        check("freeze_second", second, 7'h00);

        // Alarm hit at 00:01
        edit(3'd3, 1);
        edit(3'd4, 17);
        check("alarm_min_set", alarm_min, 7'h01);
        check("alarm_hour_set", alarm_hour, 6'h00);
        edit(3'd0, 59);
        alarm_en = 1'b1;
        adjust   = 1'b0;
        step(900);
        check("hit_pre_subsec", subsec, 8'h09);
        step(100);
        check("hit_minute", minute, 7'h01);
        check("hit_second", second, 7'h00);
        check("hit_active_pre", alarm_active, 1'b0);
        step(1);
        check("hit_active", alarm_active, 1'b1);
        alarm_ack = 1'b1;
        step(1);
        check("ack_clears", alarm_active, 1'b0);
        alarm_ack = 1'b0;
        step(1);
        check("ack_stays_idle", alarm_active, 1'b0);

        // Timeout after 3 second pulses
        adjust = 1'b1;
        edit(3'd1, 59);
        check("to_minute_wrap", minute, 7'h00);
        edit(3'd0, 59);
        adjust = 1'b0;
        step(1000);
        check("to_active_pre", alarm_active, 1'b0);
        step(1);
        check("to_active", alarm_active, 1'b1);
        step(999);
        check("to_pulse1", sec_pulse, 1'b1);
        check("to_active1", alarm_active, 1'b1);
        step(1000);
        check("to_active2", alarm_active, 1'b1);
        step(1000);
        check("to_second3", second, 7'h03);
        check("to_pulse3", sec_pulse, 1'b1);
        check("to_active3", alarm_active, 1'b1);
        step(1);
        check("to_cleared", alarm_active, 1'b0);

        // Override by adjust
        adjust = 1'b1;
        edit(3'd1, 59);
        edit(3'd0, 56);
        adjust = 1'b0;
        step(1001);
        check("ovr_adj_ring", alarm_active, 1'b1);
        adjust = 1'b1;
        step(1);
        check("ovr_adj_clear", alarm_active, 1'b0);

        // Override by alarm_en=0
        edit(3'd1, 59);
        edit(3'd0, 59);
        adjust = 1'b0;
        step(1001);
        check("ovr_en_ring", alarm_active, 1'b1);
        alarm_en = 1'b0;
        step(1);
        check("ovr_en_clear", alarm_active, 1'b0);

        // Disarmed at match time
        adjust = 1'b1;
        edit(3'd1, 59);
        edit(3'd0, 59);
        adjust = 1'b0;
        step(1000);
        check("dis_minute", minute, 7'h01);
        check("dis_second", second, 7'h00);
        step(1);
        check("dis_no_ring", alarm_active, 1'b0);
        step(5);
        check("dis_no_ring_late", alarm_active, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
